pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, default 16, sets the PC and target width in bits.
REQ-002 Parameter RESET_VECTOR, default 0, sets the PC value loaded on reset and on a restart command.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 pcEn  input  2  PC command from controller: 00 hold, 01 restart, 10 jump, 11 advance.
REQ-006 muxPc  input  1  select for the redirect: 1 means the taken/redirect path, 0 means the sequential path.
REQ-007 target  input  WIDTH  absolute jump address, taken from the output register.
REQ-008 disp  input  8  signed two's-complement branch displacement from the instruction.
REQ-009 pc  output  WIDTH  current program counter, registered.
REQ-010 pcPlus1  output  WIDTH  pc+1 modulo 2^WIDTH, combinational from pc; this is the link value for JAL.
REQ-011 redirect  output  1  registered; one-cycle pulse after any non-sequential PC update.
REQ-012 branchCount  output  16  taken-redirect counter; present only with PC_BRANCH_COUNT_EN.

Function
REQ-013 pcEn=00: pc holds; redirect=0 next cycle.
REQ-014 pcEn=01: pc<=RESET_VECTOR; redirect=1 next cycle; muxPc ignored.
REQ-015 pcEn=10, muxPc=1: pc<=target; redirect=1.
REQ-016 pcEn=10, muxPc=0: pc<=pc+1; redirect=0.
REQ-017 pcEn=11, muxPc=1: pc<=pc+sign_extend(disp); redirect=1.
REQ-018 pcEn=11, muxPc=0: pc<=pc+1; redirect=0.
REQ-019 All PC arithmetic is modulo 2^WIDTH with wrap-around and no error flag: 0xFFFF+1=0x0000; 0x0000+(-1)=0xFFFF.
REQ-020 disp is sign-extended from bit 7 to WIDTH, giving a range of -128..+127.
REQ-021 Latency: the new pc is visible one clock after the command cycle; redirect asserts in that same cycle.
REQ-022 redirect asserts for exactly one cycle per redirecting command; back-to-back redirect commands keep it high in each following cycle.
REQ-023 pcEn=11 with muxPc=1 and disp=0 still counts as a redirect: pc unchanged, redirect=1.
REQ-024 Control FSM states are RUN and RESTART.
REQ-025 Reset forces RESTART; pcEn=01 in any state also forces RESTART.
REQ-026 RESTART forces pc=RESET_VECTOR and ignores all pcEn commands except 01.
REQ-027 RESTART moves to RUN after one clock with pcEn=00.
REQ-028 RUN executes REQ-013..REQ-018.

Reset
REQ-029 Asserting reset at any time, including mid-command, immediately (asynchronously) sets pc=RESET_VECTOR, redirect=0, state=RESTART and branchCount=0.
REQ-030 On the first rising edge after reset deassertion, commands are handled per REQ-026/REQ-027.
REQ-031 pcPlus1 equals RESET_VECTOR+1 while in reset.

Configuration
REQ-032 Macro PC_BRANCH_COUNT_EN: when defined, the branchCount port and its counter are included.
REQ-033 The counter increments on each REQ-015 or REQ-017 update, saturates at 0xFFFF, is unaffected by REQ-014, and clears on reset.
REQ-034 Without PC_BRANCH_COUNT_EN, the port and counter are absent and all other behaviour is identical.

Verification
REQ-035 reset pulse; release; pcEn=00 one cycle; pcEn=11, muxPc=0 -> pc=0x0000, then 0x0001 one cycle after the command, redirect=0.
REQ-036 pc=0x0010; pcEn=11, muxPc=1, disp=0xF0 -> pc=0x0000, redirect=1 for one cycle; branchCount=1 when PC_BRANCH_COUNT_EN is defined.
REQ-037 pc=0xFFFF; pcEn=11, muxPc=0 -> pc=0x0000 (wrap), pcPlus1=0x0001.
REQ-038 pcEn=10, muxPc=1, target=0x1234, then the same command again -> pc=0x1234, redirect high for two consecutive cycles.
REQ-039 reset asserted mid-cycle during pcEn=10 -> pc=0x0000 with no clock edge, redirect=0; next command ignored per REQ-026.
REQ-040 With PC_BRANCH_COUNT_EN: 65537 taken branches -> branchCount=0xFFFF (saturated); pcEn=01 -> count unchanged.

Source files
------------

// File: rtl/pc_unit_if.sv
// Command/status bundle between the fetch controller (master) and pc_unit (slave).
// branchCount exists only when PC_BRANCH_COUNT_EN is defined.
interface pc_unit_if #(
  parameter int WIDTH = 16
);
  logic [1:0]       pcEn;
  logic             muxPc;
  logic [WIDTH-1:0] target;
  logic [7:0]       disp;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pcPlus1;
  logic             redirect;
`ifdef PC_BRANCH_COUNT_EN
  logic [15:0]      branchCount;

  modport master (
    output pcEn, muxPc, target, disp,
    input  pc, pcPlus1, redirect, branchCount
  );
  modport slave (
    input  pcEn, muxPc, target, disp,
    output pc, pcPlus1, redirect, branchCount
  );
`else
  modport master (
    output pcEn, muxPc, target, disp,
    input  pc, pcPlus1, redirect
  );
  modport slave (
    input  pcEn, muxPc, target, disp,
    output pc, pcPlus1, redirect
  );
`endif
endinterface

// File: rtl/pc_unit.sv
// Program counter with restart/jump/branch/advance commands and a one-cycle redirect pulse.
// Optional saturating taken-branch counter enabled by the PC_BRANCH_COUNT_EN macro.
module pc_unit #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic     clk,
  input  logic     reset,
  pc_unit_if.slave bus
);

  localparam logic [1:0] CMD_HOLD    = 2'b00;
  localparam logic [1:0] CMD_RESTART = 2'b01;
  localparam logic [1:0] CMD_JUMP    = 2'b10;
  localparam logic [1:0] CMD_ADVANCE = 2'b11;

  typedef enum logic {
    RUN     = 1'b0,
    RESTART = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             redirect_q, redirect_d;
  logic [WIDTH-1:0] pc_plus1;
  logic [WIDTH-1:0] disp_ext;

  assign pc_plus1 = pc_q + WIDTH'(1);
  assign disp_ext = WIDTH'($signed(bus.disp));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RESTART;
    end else begin
      state_q <= state_d;
    end
  end

  // Restart wins from any state; leaving RESTART needs one idle (hold) cycle.
  always_comb begin
    state_d = state_q;
    if (bus.pcEn == CMD_RESTART) begin
      state_d = RESTART;
    end else if ((state_q == RESTART) && (bus.pcEn == CMD_HOLD)) begin
      state_d = RUN;
    end
  end

  always_comb begin
    pc_d       = pc_q;
    redirect_d = 1'b0;
    if (bus.pcEn == CMD_RESTART) begin
      pc_d       = RESET_VECTOR;
      redirect_d = 1'b1;
    end else if (state_q == RESTART) begin
      pc_d = RESET_VECTOR;
    end else begin
      case (bus.pcEn)
        CMD_JUMP: begin
          pc_d       = bus.muxPc ? bus.target : pc_plus1;
          redirect_d = bus.muxPc;
        end
        CMD_ADVANCE: begin
          pc_d       = bus.muxPc ? (pc_q + disp_ext) : pc_plus1;
          redirect_d = bus.muxPc;
        end
        default: begin
          pc_d = pc_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_VECTOR;
      redirect_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pcPlus1  = pc_plus1;
  assign bus.redirect = redirect_q;

`ifdef PC_BRANCH_COUNT_EN
  logic [15:0] count_q, count_d;
  logic        taken;

  // Only taken jumps/branches in RUN count; restart never touches the count.
  assign taken = (state_q == RUN) && bus.pcEn[1] && bus.muxPc;

  always_comb begin
    count_d = count_q;
    if (taken && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign bus.branchCount = count_q;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed corner cases plus random commands
// compared against a behavioural model of the command rules.
module tb_pc_unit;

  localparam int WIDTH = 16;
  localparam int MOD   = 65536;
  localparam int RV    = 0;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  bit   verbose;

  // Behavioural model state
  int m_pc;
  bit m_run;
  bit m_redir;
  int m_cnt;

  pc_unit_if #(.WIDTH(WIDTH)) bus ();

  pc_unit #(
    .WIDTH       (WIDTH),
    .RESET_VECTOR(16'(RV))
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"}, 32'(bus.pc), 32'(m_pc));
    chk({tag, ".pcPlus1"}, 32'(bus.pcPlus1), 32'((m_pc + 1) % MOD));
    chk({tag, ".redirect"}, 32'(bus.redirect), 32'(m_redir));
`ifdef PC_BRANCH_COUNT_EN
    chk({tag, ".branchCount"}, 32'(bus.branchCount), 32'(m_cnt));
`endif
  endtask

  task automatic model_reset();
    m_pc    = RV;
    m_run   = 1'b0;
    m_redir = 1'b0;
    m_cnt   = 0;
  endtask

  // Apply one command to the model, following the written command rules.
  task automatic model_cmd(input logic [1:0] cmd, input logic mux, input logic [15:0] tgt,
                           input logic [7:0] d);
    int sd;
    sd = int'(d);
    if (sd >= 128) sd = sd - 256;
    if (cmd == 2'd1) begin
      m_pc    = RV;
      m_run   = 1'b0;
      m_redir = 1'b1;
    end else if (!m_run) begin
      m_pc    = RV;
      m_redir = 1'b0;
      if (cmd == 2'd0) m_run = 1'b1;
    end else if (cmd == 2'd0) begin
      m_redir = 1'b0;
    end else if (mux) begin
      m_pc    = (cmd == 2'd2) ? int'(tgt) : (((m_pc + sd) % MOD) + MOD) % MOD;
      m_redir = 1'b1;
      if (m_cnt < 65535) m_cnt++;
    end else begin
      m_pc    = (m_pc + 1) % MOD;
      m_redir = 1'b0;
    end
  endtask

  task automatic drive_edge(input logic [1:0] cmd, input logic mux, input logic [15:0] tgt,
                            input logic [7:0] d);
    bus.pcEn   = cmd;
    bus.muxPc  = mux;
    bus.target = tgt;
    bus.disp   = d;
    model_cmd(cmd, mux, tgt, d);
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [1:0] cmd, input logic mux,
                      input logic [15:0] tgt, input logic [7:0] d);
    drive_edge(cmd, mux, tgt, d);
    if (verbose)
      $display("%s: pcEn=%0d muxPc=%0d target=%04h disp=%02h -> pc=%04h redirect=%0d",
               tag, cmd, mux, tgt, d, bus.pc, bus.redirect);
    check_all(tag);
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    verbose    = 1'b1;
    reset      = 1'b1;
    bus.pcEn   = 2'd0;
    bus.muxPc  = 1'b0;
    bus.target = '0;
    bus.disp   = '0;
    model_reset();

    // Reset state, including pcPlus1 while reset is held
    #2;
    check_all("in_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Leave RESTART, then sequential advance
    step("restart_exit", 2'd0, 1'b0, 16'h0000, 8'h00);
    step("advance_seq", 2'd3, 1'b0, 16'h0000, 8'h00);

    // Backward branch to zero from 0x0010
    step("jump_0010", 2'd2, 1'b1, 16'h0010, 8'h00);
    step("branch_m16", 2'd3, 1'b1, 16'h0000, 8'hF0);
    step("hold", 2'd0, 1'b0, 16'h0000, 8'h00);

    // Wrap-around on sequential advance
    step("jump_ffff", 2'd2, 1'b1, 16'hFFFF, 8'h00);
    step("wrap_advance", 2'd3, 1'b0, 16'h0000, 8'h00);

    // Back-to-back jumps keep redirect high
    step("jump_1234_a", 2'd2, 1'b1, 16'h1234, 8'h00);
    step("jump_1234_b", 2'd2, 1'b1, 16'h1234, 8'h00);
    step("hold_after", 2'd0, 1'b0, 16'h0000, 8'h00);
    step("jump_seq", 2'd2, 1'b0, 16'hBEEF, 8'h00);

    // Zero displacement still redirects
    step("branch_zero", 2'd3, 1'b1, 16'h0000, 8'h00);

    // Restart command, commands ignored in RESTART, then resume
    step("restart_cmd", 2'd1, 1'b1, 16'h4444, 8'h11);
    step("ignored_branch", 2'd3, 1'b1, 16'h0000, 8'h05);
    step("ignored_jump", 2'd2, 1'b1, 16'h7777, 8'h00);
    step("resume", 2'd0, 1'b0, 16'h0000, 8'h00);
    step("branch_m1_wrap", 2'd3, 1'b1, 16'h0000, 8'hFF);
    step("branch_p127", 2'd3, 1'b1, 16'h0000, 8'h7F);
    step("branch_m128", 2'd3, 1'b1, 16'h0000, 8'h80);

    // Random command mix
    for (int i = 0; i < 300; i++) begin
      logic [1:0] cmd;
      int         sel;
      sel = int'($urandom_range(0, 15));
      cmd = (sel == 0) ? 2'd1 : (sel < 4) ? 2'd0 : (sel < 9) ? 2'd2 : 2'd3;
      step($sformatf("rand%0d", i), cmd, 1'($urandom_range(0, 1)),
           16'($urandom), 8'($urandom));
    end

    // Asynchronous reset in the middle of a jump command
    step("pre_async", 2'd0, 1'b0, 16'h0000, 8'h00);
    step("pre_async_jump", 2'd2, 1'b1, 16'hA5A5, 8'h00);
    bus.pcEn   = 2'd2;
    bus.muxPc  = 1'b1;
    bus.target = 16'h5555;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("async_reset");
    @(posedge clk);
    #1;
    check_all("reset_held");
    reset = 1'b0;
    step("post_reset_ignored", 2'd2, 1'b1, 16'h5555, 8'h00);
    step("post_reset_exit", 2'd0, 1'b0, 16'h0000, 8'h00);
    step("post_reset_adv", 2'd3, 1'b0, 16'h0000, 8'h00);

`ifdef PC_BRANCH_COUNT_EN
    // Saturation of the taken-branch counter
    verbose = 1'b0;
    for (int i = 0; i < 65537; i++) begin
      drive_edge(2'd3, 1'b1, 16'h0000, 8'h01);
    end
    verbose = 1'b1;
    chk("count_saturated", 32'(bus.branchCount), 32'h0000FFFF);
    check_all("after_saturation");
    step("restart_keeps_count", 2'd1, 1'b0, 16'h0000, 8'h00);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so a stalled run still reports
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit reached");
  end

endmodule
